// File: rtl/kmeans_sequencer_if.sv
// rtl/kmeans_sequencer_if.sv - control/result bundle between tracker logic and the k-means sequencer
interface kmeans_sequencer_if;
  logic            enable_in;
  logic [2:0]      num_balls_in;
  logic            new_frame_in;
  logic            km_valid_in;
  logic [6:0][8:0] km_x_in;
  logic [6:0][7:0] km_y_in;
  logic            km_rst_out;
  logic            km_new_frame_out;
  logic [2:0]      km_num_balls_out;
  logic [6:0][8:0] seed_x_out;
  logic [6:0][7:0] seed_y_out;
  logic [6:0][8:0] centroids_x_out;
  logic [6:0][7:0] centroids_y_out;
  logic            valid_out;
  logic            timeout_out;
  logic [7:0]      drop_count_out;

  // sequencer side
  modport slave (
    input  enable_in, num_balls_in, new_frame_in, km_valid_in, km_x_in, km_y_in,
    output km_rst_out, km_new_frame_out, km_num_balls_out, seed_x_out, seed_y_out,
    output centroids_x_out, centroids_y_out, valid_out, timeout_out, drop_count_out
  );

  // driver / consumer side
  modport master (
    output enable_in, num_balls_in, new_frame_in, km_valid_in, km_x_in, km_y_in,
    input  km_rst_out, km_new_frame_out, km_num_balls_out, seed_x_out, seed_y_out,
    input  centroids_x_out, centroids_y_out, valid_out, timeout_out, drop_count_out
  );
endinterface

// File: rtl/kmeans_sequencer.sv
// rtl/kmeans_sequencer.sv - frame-by-frame seeding, solve supervision and result publishing for k-means
module kmeans_sequencer #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int DEF_X0         = 24,
  parameter int DEF_DX         = 40,
  parameter int DEF_Y          = 90
) (
  input logic               clk_in,
  input logic               rst_in,
  kmeans_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    DISABLED,
    SEED_LOAD,
    SEED_RST,
    CAPTURE,
    SOLVE,
    WAIT_FRAME
  } state_t;

  localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [20:0]     count;
  logic            have_result;
  logic [2:0]      balls_clamped;
  logic            count_changed;
  logic [6:0][8:0] def_x;
  logic [6:0][7:0] def_y;

  // zero clusters makes no sense to the datapath, so it is run as one
  assign balls_clamped = (bus.num_balls_in == 3'd0) ? 3'd1 : bus.num_balls_in;
  assign count_changed = (balls_clamped != bus.km_num_balls_out);

  // evenly spaced default seeds along one row
  always_comb begin
    def_x = '0;
    def_y = '0;
    for (int i = 0; i < 7; i++) begin
      def_x[i] = 9'(DEF_X0 + i * DEF_DX);
      def_y[i] = 8'(DEF_Y);
    end
  end

  // sequencer FSM; every output is a register updated alongside the state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                <= DISABLED;
      count                <= '0;
      have_result          <= 1'b0;
      bus.km_rst_out       <= 1'b1;
      bus.km_new_frame_out <= 1'b0;
      bus.km_num_balls_out <= '0;
      bus.seed_x_out       <= '0;
      bus.seed_y_out       <= '0;
      bus.centroids_x_out  <= '0;
      bus.centroids_y_out  <= '0;
      bus.valid_out        <= 1'b0;
      bus.timeout_out      <= 1'b0;
      bus.drop_count_out   <= '0;
    end else begin
      bus.km_rst_out       <= 1'b0;
      bus.km_new_frame_out <= 1'b0;
      bus.valid_out        <= 1'b0;
      bus.timeout_out      <= 1'b0;
      if (!bus.enable_in) begin
        state          <= DISABLED;
        bus.km_rst_out <= 1'b1;
      end else begin
        case (state)
          DISABLED: state <= SEED_LOAD;
          SEED_LOAD: begin
            // warm-start from the previous solution only if the cluster count is the same
            if (have_result && !count_changed) begin
              bus.seed_x_out <= bus.centroids_x_out;
              bus.seed_y_out <= bus.centroids_y_out;
            end else begin
              bus.seed_x_out <= def_x;
              bus.seed_y_out <= def_y;
            end
            bus.km_num_balls_out <= balls_clamped;
            bus.km_rst_out       <= 1'b1;
            state                <= SEED_RST;
          end
          SEED_RST: state <= CAPTURE;
          CAPTURE: begin
            if (count_changed) begin
              state <= SEED_LOAD;
            end else if (bus.new_frame_in) begin
              bus.km_new_frame_out <= 1'b1;
              count                <= '0;
              state                <= SOLVE;
            end
          end
          SOLVE: begin
            if (count_changed) begin
              state <= SEED_LOAD;
            end else begin
              count <= count + 21'd1;
              // the datapath is busy, so any frame arriving now is lost
              if (bus.new_frame_in && bus.drop_count_out != 8'hff)
                bus.drop_count_out <= bus.drop_count_out + 8'd1;
              if (bus.km_valid_in) begin
                for (int i = 0; i < 7; i++) begin
                  bus.centroids_x_out[i] <= (3'(i) < bus.km_num_balls_out) ? bus.km_x_in[i] : 9'd0;
                  bus.centroids_y_out[i] <= (3'(i) < bus.km_num_balls_out) ? bus.km_y_in[i] : 8'd0;
                end
                bus.valid_out <= 1'b1;
                have_result   <= 1'b1;
                state         <= WAIT_FRAME;
              end else if (count == TIMEOUT_LAST) begin
                bus.timeout_out <= 1'b1;
                have_result     <= 1'b0;
                state           <= SEED_LOAD;
              end
            end
          end
          WAIT_FRAME: begin
            if (count_changed) begin
              state <= SEED_LOAD;
            end else if (bus.new_frame_in) begin
              bus.km_new_frame_out <= 1'b1;
              state                <= CAPTURE;
            end
          end
          default: state <= DISABLED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kmeans_sequencer.sv
// tb/tb_kmeans_sequencer.sv - directed self-checking bench for kmeans_sequencer
module tb_kmeans_sequencer;
  logic clk_in;
  logic rst_in;
  int   n_checks;
  int   n_pass;

  kmeans_sequencer_if bus ();

  kmeans_sequencer #(
    .TIMEOUT_CYCLES(16),
    .DEF_X0(24),
    .DEF_DX(40),
    .DEF_Y(90)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  // free-running clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // directed scenarios
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_in   = 1'b0;
    bus.enable_in    = 1'b0;
    bus.num_balls_in = 3'd3;
    bus.new_frame_in = 1'b0;
    bus.km_valid_in  = 1'b0;
    bus.km_x_in      = '0;
    bus.km_y_in      = '0;
    #12;
    check("rst_km_rst", 32'(bus.km_rst_out), 32'd1);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_timeout", 32'(bus.timeout_out), 32'd0);
    check("rst_drop", 32'(bus.drop_count_out), 32'd0);
    check("rst_seed_x0", 32'(bus.seed_x_out[0]), 32'd0);
    check("rst_nballs", 32'(bus.km_num_balls_out), 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    tick();
    check("dis_km_rst", 32'(bus.km_rst_out), 32'd1);

    // enable: km_rst dips in SEED_LOAD, pulses in SEED_RST only
    bus.enable_in = 1'b1;
    tick();
    check("seedload_km_rst", 32'(bus.km_rst_out), 32'd0);
    tick();
    check("seedrst_km_rst", 32'(bus.km_rst_out), 32'd1);
    check("def_seed_x0", 32'(bus.seed_x_out[0]), 32'd24);
    check("def_seed_x1", 32'(bus.seed_x_out[1]), 32'd64);
    check("def_seed_x2", 32'(bus.seed_x_out[2]), 32'd104);
    check("def_seed_x6", 32'(bus.seed_x_out[6]), 32'd264);
    check("def_seed_y3", 32'(bus.seed_y_out[3]), 32'd90);
    check("nballs_3", 32'(bus.km_num_balls_out), 32'd3);
    tick();
    check("capture_km_rst", 32'(bus.km_rst_out), 32'd0);

    // frame into SOLVE, second frame dropped, then result
    bus.new_frame_in = 1'b1;
    tick();
    check("fwd_frame", 32'(bus.km_new_frame_out), 32'd1);
    tick();
    check("solve_no_fwd", 32'(bus.km_new_frame_out), 32'd0);
    check("drop_1", 32'(bus.drop_count_out), 32'd1);
    bus.new_frame_in = 1'b0;
    bus.km_x_in[0] = 9'd100;
    bus.km_y_in[0] = 8'd50;
    bus.km_x_in[2] = 9'd33;
    bus.km_x_in[3] = 9'd77;
    bus.km_y_in[4] = 8'd12;
    bus.km_valid_in = 1'b1;
    tick();
    bus.km_valid_in = 1'b0;
    check("valid_pulse", 32'(bus.valid_out), 32'd1);
    check("cent_x0", 32'(bus.centroids_x_out[0]), 32'd100);
    check("cent_y0", 32'(bus.centroids_y_out[0]), 32'd50);
    check("cent_x2", 32'(bus.centroids_x_out[2]), 32'd33);
    check("cent_x3_zero", 32'(bus.centroids_x_out[3]), 32'd0);
    check("cent_y4_zero", 32'(bus.centroids_y_out[4]), 32'd0);
    tick();
    check("valid_one_cycle", 32'(bus.valid_out), 32'd0);

    // km_valid in WAIT_FRAME is ignored
    bus.km_x_in[0] = 9'd7;
    bus.km_valid_in = 1'b1;
    tick();
    bus.km_valid_in = 1'b0;
    check("wait_valid_ign", 32'(bus.valid_out), 32'd0);
    check("wait_cent_hold", 32'(bus.centroids_x_out[0]), 32'd100);

    // disable keeps result; re-enable warm-starts from it
    bus.enable_in = 1'b0;
    tick();
    check("dis2_km_rst", 32'(bus.km_rst_out), 32'd1);
    check("dis2_cent_hold", 32'(bus.centroids_x_out[0]), 32'd100);
    bus.enable_in = 1'b1;
    tick();
    tick();
    check("warm_seed_x0", 32'(bus.seed_x_out[0]), 32'd100);
    check("warm_seed_y0", 32'(bus.seed_y_out[0]), 32'd50);
    check("warm_seed_x3", 32'(bus.seed_x_out[3]), 32'd0);
    tick();
    bus.new_frame_in = 1'b1;
    tick();
    bus.new_frame_in = 1'b0;
    check("fwd_frame2", 32'(bus.km_new_frame_out), 32'd1);

    // timeout after 16 SOLVE cycles, then default reseed
    repeat (15) tick();
    check("no_timeout_15", 32'(bus.timeout_out), 32'd0);
    tick();
    check("timeout_16", 32'(bus.timeout_out), 32'd1);
    check("to_cent_hold", 32'(bus.centroids_x_out[0]), 32'd100);
    tick();
    check("timeout_pulse", 32'(bus.timeout_out), 32'd0);
    check("to_km_rst", 32'(bus.km_rst_out), 32'd1);
    check("to_seed_x0", 32'(bus.seed_x_out[0]), 32'd24);

    // count change in SOLVE beats new frame and valid
    tick();
    bus.new_frame_in = 1'b1;
    tick();
    bus.new_frame_in = 1'b0;
    tick();
    bus.num_balls_in = 3'd5;
    bus.new_frame_in = 1'b1;
    bus.km_x_in[0] = 9'd123;
    bus.km_valid_in = 1'b1;
    tick();
    bus.new_frame_in = 1'b0;
    bus.km_valid_in = 1'b0;
    check("chg_no_fwd", 32'(bus.km_new_frame_out), 32'd0);
    check("chg_no_valid", 32'(bus.valid_out), 32'd0);
    check("chg_cent_hold", 32'(bus.centroids_x_out[0]), 32'd100);
    tick();
    check("chg_nballs5", 32'(bus.km_num_balls_out), 32'd5);
    check("chg_seed_x0", 32'(bus.seed_x_out[0]), 32'd24);
    check("chg_seed_x4", 32'(bus.seed_x_out[4]), 32'd184);
    check("chg_km_rst", 32'(bus.km_rst_out), 32'd1);

    // valid on the terminal count wins over timeout
    tick();
    bus.new_frame_in = 1'b1;
    tick();
    bus.new_frame_in = 1'b0;
    repeat (15) tick();
    bus.km_x_in = '0;
    bus.km_x_in[0] = 9'd11;
    bus.km_x_in[4] = 9'd200;
    bus.km_x_in[5] = 9'd99;
    bus.km_valid_in = 1'b1;
    tick();
    bus.km_valid_in = 1'b0;
    check("term_valid", 32'(bus.valid_out), 32'd1);
    check("term_no_timeout", 32'(bus.timeout_out), 32'd0);
    check("term_cent_x4", 32'(bus.centroids_x_out[4]), 32'd200);
    check("term_cent_x5", 32'(bus.centroids_x_out[5]), 32'd0);

    // asynchronous reset in the middle of SOLVE
    bus.new_frame_in = 1'b1;
    tick();
    tick();
    bus.new_frame_in = 1'b0;
    tick();
    #2 rst_in = 1'b0;
    #1;
    check("arst_km_rst", 32'(bus.km_rst_out), 32'd1);
    check("arst_cent_x0", 32'(bus.centroids_x_out[0]), 32'd0);
    check("arst_seed_x0", 32'(bus.seed_x_out[0]), 32'd0);
    check("arst_drop", 32'(bus.drop_count_out), 32'd0);
    check("arst_nballs", 32'(bus.km_num_balls_out), 32'd0);
    bus.enable_in    = 1'b0;
    bus.num_balls_in = 3'd0;
    tick();
    rst_in = 1'b1;
    tick();

    // zero clusters clamp to one; drop counter saturates
    bus.enable_in = 1'b1;
    tick();
    tick();
    check("clamp_nballs", 32'(bus.km_num_balls_out), 32'd1);
    tick();
    bus.new_frame_in = 1'b1;
    repeat (400) tick();
    bus.new_frame_in = 1'b0;
    check("drop_sat", 32'(bus.drop_count_out), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/kmeans_sequencer.md
KMEANS_SEQUENCER -- requirements
Module: kmeans_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2_000_000, max SOLVE cycles before abort (counter 21 bits).
REQ-002 Parameter DEF_X0, default 24, default seed x of centroid 0.
REQ-003 Parameter DEF_DX, default 40, default seed x spacing.
REQ-004 Parameter DEF_Y, default 90, default seed y for all centroids.
REQ-005 clk_in  input  1  sole clock.
REQ-006 rst_in  input  1  asynchronous active-low reset.
REQ-007 enable_in  input  1  run tracking when high.
REQ-008 num_balls_in  input  3  requested cluster count; 0 treated as 1.
REQ-009 new_frame_in  input  1  one-cycle frame-boundary pulse from camera path.
REQ-010 km_valid_in  input  1  k-means done pulse.
REQ-011 km_x_in / km_y_in  input  7x9 / 7x8  k-means centroid results.
REQ-012 km_rst_out  output  1  active-high synchronous reset to k-means datapath.
REQ-013 km_new_frame_out  output  1  gated frame pulse to k-means.
REQ-014 km_num_balls_out  output  3  cluster count presented to k-means.
REQ-015 seed_x_out / seed_y_out  output  7x9 / 7x8  seed centroids to k-means.
REQ-016 centroids_x_out / centroids_y_out  output  7x9 / 7x8  latest published result.
REQ-017 valid_out  output  1  one-cycle pulse, new result published.
REQ-018 timeout_out  output  1  one-cycle pulse, SOLVE aborted.
REQ-019 drop_count_out  output  8  saturating count of frames dropped during SOLVE.

Function
REQ-020 FSM states: DISABLED, SEED_LOAD, SEED_RST, CAPTURE, SOLVE, WAIT_FRAME; all outputs registered.
REQ-021 DISABLED: km_rst_out=1; enable_in high -> SEED_LOAD next cycle.
REQ-022 SEED_LOAD (1 cycle): km_num_balls_out <= clamped num_balls_in; seeds <= last result if have_result and count unchanged, else defaults; -> SEED_RST.
REQ-023 Default seeds: seed_x[i]=DEF_X0+i*DEF_DX (9-bit), seed_y[i]=DEF_Y, all 7 entries.
REQ-024 SEED_RST (1 cycle): km_rst_out=1, seeds stable; -> CAPTURE. km_rst_out=0 in CAPTURE, SOLVE, WAIT_FRAME.
REQ-025 CAPTURE: new_frame_in -> km_new_frame_out=1 same-cycle-registered (next cycle), -> SOLVE, timeout counter cleared.
REQ-026 SOLVE: counter +1 per cycle; km_valid_in -> latch km_x_in/km_y_in into centroids_*_out (entries >= km_num_balls_out forced 0), valid_out=1 next cycle, have_result=1, -> WAIT_FRAME.
REQ-027 SOLVE: counter reaching TIMEOUT_CYCLES-1 with no km_valid_in -> timeout_out=1, have_result=0, -> SEED_LOAD.
REQ-028 SOLVE: new_frame_in not forwarded; drop_count_out +1, saturating at 255.
REQ-029 WAIT_FRAME: new_frame_in -> km_new_frame_out=1, -> CAPTURE.
REQ-030 km_valid_in outside SOLVE ignored.
REQ-031 Clamped num_balls_in != km_num_balls_out in CAPTURE/SOLVE/WAIT_FRAME -> SEED_LOAD with default seeds; wins over simultaneous new_frame_in (not forwarded) and km_valid_in (not latched).
REQ-032 Same cycle km_valid_in and timeout terminal: valid wins.
REQ-033 enable_in low in any state -> DISABLED next cycle; have_result retained; no valid_out.
REQ-034 centroids_*_out hold last value until next latch; unchanged by timeout or disable.

Reset
REQ-035 rst_in low: state DISABLED, km_rst_out=1, all other outputs 0, counter 0, have_result 0, drop_count 0; effective immediately, mid-operation included.
REQ-036 Release of rst_in synchronous to clk_in; first transition earliest on first rising edge after release.

Verification
REQ-037 enable_in=1 at cycle t, num_balls_in=3 -> km_rst_out=1 at t+2 only, seed_x=24,64,104,...,264, seed_y=90.
REQ-038 Two new_frame_in pulses, km_valid_in with x0=100,y0=50 -> valid_out one cycle later, centroids_x_out[0]=100, entries 3..6 = 0.
REQ-039 TIMEOUT_CYCLES=16, no km_valid_in -> timeout_out after 16 SOLVE cycles, reseed with defaults.
REQ-040 num_balls_in 3->5 during SOLVE with simultaneous new_frame_in -> no km_new_frame_out, SEED_LOAD, default seeds, km_num_balls_out=5.
REQ-041 300 new_frame_in pulses during SOLVE -> drop_count_out=255.
REQ-042 rst_in low mid-SOLVE -> outputs zero, km_rst_out=1 immediately.
